// File: rtl/seg7_frame_gen.sv
// rtl/seg7_frame_gen.sv - hex/point/blank to active-low 7-segment frame feeder for the serial display shifter.
// Snapshots the encoded frame, pulses sync, then tracks sen for completion or stall.
module seg7_frame_gen #(
  parameter int DIGITS         = 8,
  parameter int REFRESH_CYCLES = 50000,
  parameter int SYNC_HIGH      = 4,
  parameter int ACK_LIMIT      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  update,
  input  logic                  sen,
  output logic [8*DIGITS-1:0]   data,
  output logic                  sync,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int RW   = $clog2(REFRESH_CYCLES);
  localparam int CMAX = (SYNC_HIGH > ACK_LIMIT) ? SYNC_HIGH : ACK_LIMIT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_HIGH - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_PULSE,
    S_ACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       refresh_q, refresh_d;
  logic                tick_q, tick_d;
  logic                pending_q, pending_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [8*DIGITS-1:0] data_q, data_d;
  logic                sync_q, sync_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [8*DIGITS-1:0] frame_enc;
  logic [7:0]          seg_tmp;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Blank wins over both the digit value and its decimal point.
  always_comb begin
    frame_enc = '1;
    seg_tmp   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg_tmp = hex_to_seg(hex[4*i +: 4]);
      if (point[i]) seg_tmp[7] = 1'b0;
      if (blank[i]) seg_tmp = 8'hFF;
      frame_enc[8*i +: 8] = seg_tmp;
    end
  end

  always_comb begin
    tick_d    = (refresh_q == REF_LAST);
    refresh_d = tick_d ? '0 : refresh_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = '0;
    timeout_d = 1'b0;
    data_d    = data_q;

    if (update && state_q != S_IDLE) pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick_q || update || pending_q) begin
          state_d   = S_SNAP;
          pending_d = 1'b0;
        end
      end
      S_SNAP: state_d = S_PULSE;
      S_PULSE: begin
        if (cnt_q == SYNC_LAST) state_d = S_ACK;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_ACK: begin
        if (!sen) begin
          state_d = S_DRAIN;
        end else if (cnt_q == ACK_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (sen) state_d = S_DONE;
      end
      S_DONE: begin
        // A request queued during the frame starts right away, skipping IDLE.
        if (pending_q || update) begin
          state_d   = S_SNAP;
          pending_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load on entry so data leads the sync rise by the whole SNAP cycle.
    if (state_d == S_SNAP) data_d = frame_enc;
  end

  always_comb begin
    sync_d = (state_d == S_PULSE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      refresh_q <= '0;
      tick_q    <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '1;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      refresh_q <= refresh_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sync_q    <= sync_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign data    = data_q;
  assign sync    = sync_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule
